// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and the iteration counter width helper.
package muldiv_pkg;

  // Operation encodings; op[1] selects divide, op[0] selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Start/done handshake and operand/result bus between the control unit
// (master) and the multiply/divide unit (slave).
interface muldiv_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_magnitude.sv
// Conditional two's-complement negate. Used both to take operand absolute
// values and to restore the sign of results.
module muldiv_magnitude #(
  parameter int N = 32
) (
  input  logic [N-1:0] x_i,
  input  logic         neg_i,
  output logic [N-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + {{(N-1){1'b0}}, 1'b1}) : x_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Shift-add multiply and restoring divide
// over unsigned magnitudes, one bit per cycle, followed by a single sign
// correction cycle. Divide by zero is flagged immediately from IDLE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset,
  muldiv_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   opa_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic               busy_q;
  logic               done_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // Operand magnitudes taken straight from the bus so they can be latched
  // at the start edge.
  logic             signed_in;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign signed_in = ~bus.op[0];

  muldiv_magnitude #(.N(WIDTH)) u_abs_a (
    .x_i   (bus.a),
    .neg_i (signed_in & bus.a[WIDTH-1]),
    .y_o   (abs_a)
  );

  muldiv_magnitude #(.N(WIDTH)) u_abs_b (
    .x_i   (bus.b),
    .neg_i (signed_in & bus.b[WIDTH-1]),
    .y_o   (abs_b)
  );

  // Multiply step: the low half of acc_q initially holds the multiplier;
  // each step conditionally adds the multiplicand to the high half and
  // shifts the whole accumulator right, carry included.
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_d;

  assign mul_addend = acc_q[0] ? opa_q : {WIDTH{1'b0}};
  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
  assign mul_acc_d  = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc_q[WIDTH-1:0] shifts the dividend out at the top and
  // the quotient in at the bottom. The partial remainder is WIDTH+1 bits
  // once shifted; since it is always below twice the divisor, the borrow
  // bit of the trial subtraction alone decides the quotient bit.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;

  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_sub   = div_shift - {1'b0, opb_q};
  assign div_ge    = ~div_sub[WIDTH];
  assign div_rem_d = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_d = {acc_q[WIDTH-2:0], div_ge};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  muldiv_magnitude #(.N(2*WIDTH)) u_fix_prod (
    .x_i   (acc_q),
    .neg_i (neg_res_q),
    .y_o   (prod_fix)
  );

  muldiv_magnitude #(.N(WIDTH)) u_fix_quo (
    .x_i   (acc_q[WIDTH-1:0]),
    .neg_i (neg_res_q),
    .y_o   (quo_fix)
  );

  muldiv_magnitude #(.N(WIDTH)) u_fix_rem (
    .x_i   (rem_q),
    .neg_i (neg_rem_q),
    .y_o   (rem_fix)
  );

  // Control FSM with operand latch, iteration datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.op[1] && (bus.b == '0)) begin
              // Divide by zero: report at once, keep previous results.
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              cnt_q     <= CNT_W'(WIDTH);
              is_div_q  <= bus.op[1];
              neg_res_q <= signed_in & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              neg_rem_q <= signed_in & bus.a[WIDTH-1];
              opa_q     <= abs_a;
              opb_q     <= abs_b;
              acc_q     <= {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
              rem_q     <= '0;
            end
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (is_div_q) begin
              acc_q <= {{WIDTH{1'b0}}, div_quo_d};
              rem_q <= div_rem_d;
            end else begin
              acc_q <= mul_acc_d;
            end
          end else begin
            state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance, a table of known
// vectors, hand sequences for busy/back-to-back/reset behaviour, and random
// operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    int          w;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] last_hi [2];
  logic [31:0] last_lo [2];

  muldiv_if #(.WIDTH(32)) if32 ();
  muldiv_if #(.WIDTH(8))  if8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 8) begin
      if8.start = s; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end else begin
      if32.start = s; if32.op = op; if32.a = a; if32.b = b;
    end
  endtask

  task automatic sample(input int w, output logic d, output logic bz, output logic dz,
                        output logic [31:0] hi, output logic [31:0] lo);
    if (w == 8) begin
      d = if8.done; bz = if8.busy; dz = if8.div_zero;
      hi = {24'd0, if8.hi}; lo = {24'd0, if8.lo};
    end else begin
      d = if32.done; bz = if32.busy; dz = if32.div_zero;
      hi = if32.hi; lo = if32.lo;
    end
  endtask

  // Pulse start for one edge; afterwards scramble a/b so only latched copies matter.
  task automatic start_op(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(w, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, op, $urandom, $urandom);
  endtask

  // k = number of edges after the start edge until done is seen.
  task automatic wait_done(input int w, output int k, output int bc);
    logic d, bz, dz;
    logic [31:0] hi, lo;
    k = 0; bc = 0;
    sample(w, d, bz, dz, hi, lo);
    if (bz) bc++;
    while (!d && k < 200) begin
      @(posedge clk); #1;
      k++;
      sample(w, d, bz, dz, hi, lo);
      if (bz) bc++;
    end
  endtask

  task automatic run_vec(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input string tag);
    int k, bc, elat;
    logic d, bz, dz;
    logic [31:0] hi, lo;
    elat = edz ? 0 : w + 2;
    start_op(w, op, a, b);
    wait_done(w, k, bc);
    sample(w, d, bz, dz, hi, lo);
    check({tag, ".latency"}, k, elat);
    check({tag, ".busy_cycles"}, bc, elat);
    check({tag, ".hi"}, hi, ehi);
    check({tag, ".lo"}, lo, elo);
    check({tag, ".div_zero"}, {31'd0, dz}, {31'd0, edz});
    @(posedge clk); #1;
    sample(w, d, bz, dz, hi, lo);
    check({tag, ".done_pulse"}, {31'd0, d}, 32'd0);
  endtask

  // Reference arithmetic on w-bit operands using 64-bit integers.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] mask, ua, ub, p;
    longint      sa, sb, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    p  = 64'd0;
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MULT, MULTU: begin
        if (op == MULT) p = sa * sb;
        else            p = ua * ub;
        hi = 32'((p >> w) & mask);
        lo = 32'(p & mask);
      end
      DIV: begin
        sq = sa / sb;
        sr = sa % sb;
        lo = 32'(sq) & mask[31:0];
        hi = 32'(sr) & mask[31:0];
      end
      default: begin
        lo = 32'(ua / ub);
        hi = 32'(ua % ub);
      end
    endcase
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = mask;
      3:       v = 32'd1 << (w - 1);
      default: v = $urandom;
    endcase
    return v & mask;
  endfunction

  task automatic rand_run(input int w, input int n);
    logic [1:0]  op;
    logic [31:0] a, b, ehi, elo;
    logic        edz;
    int          s;
    s = (w == 8) ? 1 : 0;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick(w);
      b  = pick(w);
      if (op[1] && b == 32'd0) begin
        edz = 1'b1; ehi = last_hi[s]; elo = last_lo[s];
      end else begin
        edz = 1'b0;
        model(w, op, a, b, ehi, elo);
        last_hi[s] = ehi; last_lo[s] = elo;
      end
      run_vec(w, op, a, b, ehi, elo, edz, $sformatf("rnd%0d_%0d", w, i));
    end
  endtask

  vec_t vecs [18];

  initial begin
    int k, bc, dcount, bcount;
    logic d, bz, dz;
    logic [31:0] hi, lo;

    vecs[0]  = '{32, MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{32, MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[2]  = '{32, MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{32, DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{32, DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{32, DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[6]  = '{32, MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0};
    vecs[7]  = '{32, DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{32, DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vecs[9]  = '{32, MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};
    vecs[10] = '{32, MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0};
    vecs[11] = '{32, DIVU,  32'd95,        32'd10,        32'd5,         32'd9,         1'b0};
    vecs[12] = '{32, DIVU,  32'd100,       32'd0,         32'd5,         32'd9,         1'b1};
    vecs[13] = '{32, DIV,   32'd5,         32'd0,         32'd5,         32'd9,         1'b1};
    vecs[14] = '{8,  DIVU,  32'd200,       32'd7,         32'd4,         32'd28,        1'b0};
    vecs[15] = '{8,  MULT,  32'hFD,        32'h07,        32'hFF,        32'hEB,        1'b0};
    vecs[16] = '{8,  DIV,   32'h80,        32'hFF,        32'h00,        32'h80,        1'b0};
    vecs[17] = '{8,  MULTU, 32'hFF,        32'hFF,        32'hFE,        32'h01,        1'b0};

    // Reset state
    reset = 1'b1;
    drive(32, 1'b0, MULT, 32'd0, 32'd0);
    drive(8, 1'b0, MULT, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    for (int w = 8; w <= 32; w += 24) begin
      sample(w, d, bz, dz, hi, lo);
      check($sformatf("reset%0d.busy", w), {31'd0, bz}, 32'd0);
      check($sformatf("reset%0d.done", w), {31'd0, d}, 32'd0);
      check($sformatf("reset%0d.div_zero", w), {31'd0, dz}, 32'd0);
      check($sformatf("reset%0d.hi", w), hi, 32'd0);
      check($sformatf("reset%0d.lo", w), lo, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Known vectors
    for (int i = 0; i < 18; i++)
      run_vec(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
              $sformatf("vec%0d", i));

    // start while busy is ignored
    start_op(32, MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (4) @(posedge clk);
    #1;
    drive(32, 1'b1, MULT, 32'd3, 32'd3);
    @(posedge clk); #1;
    drive(32, 1'b0, MULT, 32'd0, 32'd0);
    wait_done(32, k, bc);
    sample(32, d, bz, dz, hi, lo);
    check("ignore.latency", k, 32'd29);
    check("ignore.hi", hi, 32'd1);
    check("ignore.lo", lo, 32'hFFFF_FFFE);

    // start raised during the done cycle is accepted
    start_op(32, MULTU, 32'hFFFF_FFFF, 32'd3);
    wait_done(32, k, bc);
    sample(32, d, bz, dz, hi, lo);
    check("b2b.latency", k, 32'd34);
    check("b2b.busy_cycles", bc, 32'd34);
    check("b2b.hi", hi, 32'd2);
    check("b2b.lo", lo, 32'hFFFF_FFFD);

    // Reset in the middle of a DIVU
    start_op(32, DIVU, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    sample(32, d, bz, dz, hi, lo);
    check("midop.busy_before_reset", {31'd0, bz}, 32'd1);
    reset = 1'b1;
    #1;
    sample(32, d, bz, dz, hi, lo);
    check("midop.busy", {31'd0, bz}, 32'd0);
    check("midop.done", {31'd0, d}, 32'd0);
    check("midop.hi", hi, 32'd0);
    check("midop.lo", lo, 32'd0);
    sample(8, d, bz, dz, hi, lo);
    check("midop.lo8", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    bcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      sample(32, d, bz, dz, hi, lo);
      if (d) dcount++;
      if (bz) bcount++;
    end
    check("midop.no_done_after_reset", dcount, 32'd0);
    check("midop.no_busy_after_reset", bcount, 32'd0);

    // Random operations against the reference model
    last_hi[0] = 32'd0; last_lo[0] = 32'd0;
    last_hi[1] = 32'd0; last_lo[1] = 32'd0;
    rand_run(32, 150);
    rand_run(8, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
